// File: rtl/dekatron_chain.sv
// rtl/dekatron_chain.sv - cascaded one-hot dekatron counter rings with digit-serial carry/borrow ripple
// Optional build macro: DEKATRON_ONEHOT_CHECK_EN (sanitise non-one-hot load digits, sticky error flag)
module dekatron_chain #(
   parameter int DIGITS = 3,
   parameter int RADIX  = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    step,
   input  logic                    reverse,
   input  logic                    set,
   input  logic [DIGITS*RADIX-1:0] in,
   output logic [DIGITS*RADIX-1:0] out,
   output logic                    busy,
   output logic                    wrap_out,
   output logic                    zero,
   output logic                    error
);

   localparam int W  = DIGITS * RADIX;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [RADIX-1:0] POS0 = RADIX'(1);

   typedef enum logic {IDLE, RIPPLE} state_t;

   state_t          state, state_n;
   logic [W-1:0]    digits_q, digits_n;
   logic [IW-1:0]   idx_q, idx_n;
   logic            dir_q, dir_n;
   logic            wrap_q, wrap_n;
   logic [W-1:0]    load_value;
   logic            carry;

   // one ring position forward (down=0) or backward (down=1)
   function automatic logic [RADIX-1:0] rotate(input logic [RADIX-1:0] d, input logic down);
      return down ? {d[0], d[RADIX-1:1]} : {d[RADIX-2:0], d[RADIX-1]};
   endfunction

   // the glow leaves the ring edge: last position going up, first going down
   function automatic logic wraps(input logic [RADIX-1:0] d, input logic down);
      return down ? d[0] : d[RADIX-1];
   endfunction

`ifdef DEKATRON_ONEHOT_CHECK_EN
   logic load_bad;
   logic err_q;

   // replace every load digit that is not exactly one-hot by position 0
   always_comb begin
      load_value = in;
      load_bad   = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (in[d*RADIX +: RADIX] == '0 ||
             (in[d*RADIX +: RADIX] & (in[d*RADIX +: RADIX] - RADIX'(1))) != '0) begin
            load_value[d*RADIX +: RADIX] = POS0;
            load_bad = 1'b1;
         end
      end
   end

   // sticky flag, re-evaluated by every load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   err_q <= 1'b0;
      else if (set) err_q <= load_bad;
   end

   assign error = err_q;
`else
   assign load_value = in;
   assign error      = 1'b0;
`endif

   // next-state: load beats an accepted step, which beats the ripple
   always_comb begin
      state_n  = state;
      digits_n = digits_q;
      idx_n    = idx_q;
      dir_n    = dir_q;
      wrap_n   = 1'b0;
      carry    = 1'b0;
      if (set) begin
         digits_n = load_value;
         idx_n    = '0;
         state_n  = IDLE;
      end else if (state == IDLE) begin
         if (step) begin
            dir_n = reverse;
            digits_n[0 +: RADIX] = rotate(digits_q[0 +: RADIX], reverse);
            if (wraps(digits_q[0 +: RADIX], reverse)) begin
               if (DIGITS > 1) begin
                  state_n = RIPPLE;
                  idx_n   = IW'(1);
               end else begin
                  wrap_n = 1'b1;
               end
            end
         end
      end else begin
         for (int d = 0; d < DIGITS; d++) begin
            if (IW'(d) == idx_q) begin
               digits_n[d*RADIX +: RADIX] = rotate(digits_q[d*RADIX +: RADIX], dir_q);
               carry = wraps(digits_q[d*RADIX +: RADIX], dir_q);
            end
         end
         if (!carry) begin
            state_n = IDLE;
         end else if (idx_q == IW'(DIGITS - 1)) begin
            wrap_n  = 1'b1;
            state_n = IDLE;
         end else begin
            idx_n = idx_q + IW'(1);
         end
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         digits_q <= {DIGITS{POS0}};
         idx_q    <= '0;
         dir_q    <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state    <= state_n;
         digits_q <= digits_n;
         idx_q    <= idx_n;
         dir_q    <= dir_n;
         wrap_q   <= wrap_n;
      end
   end

   assign out      = digits_q;
   assign busy     = (state == RIPPLE);
   assign wrap_out = wrap_q;
   assign zero     = (digits_q == {DIGITS{POS0}});

endmodule

// File: tb/tb_dekatron_chain.sv
// tb/tb_dekatron_chain.sv - randomized self-checking bench for dekatron_chain against a decimal-value model
module tb_dekatron_chain;

   localparam int D   = 3;
   localparam int R   = 10;
   localparam int MOD = R ** D;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             step = 1'b0;
   logic             reverse = 1'b0;
   logic             set = 1'b0;
   logic [D*R-1:0]   in = '0;
   logic [D*R-1:0]   out;
   logic             busy, wrap_out, zero, error;

   int n_checks = 0;
   int n_errors = 0;
   int v = 0;

   dekatron_chain #(.DIGITS(D), .RADIX(R)) dut (
      .clk(clk), .rst_n(rst_n), .step(step), .reverse(reverse), .set(set),
      .in(in), .out(out), .busy(busy), .wrap_out(wrap_out), .zero(zero), .error(error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [D*R-1:0] enc(input int val);
      logic [D*R-1:0] r;
      int x;
      r = '0;
      x = val;
      for (int d = 0; d < D; d++) begin
         r[d*R + (x % R)] = 1'b1;
         x = x / R;
      end
      return r;
   endfunction

   function automatic int trail(input int val, input int dv);
      int x, t;
      x = val;
      t = 0;
      while (t < D && (x % R) == dv) begin
         t++;
         x = x / R;
      end
      return t;
   endfunction

   task automatic do_set(input int val);
      set = 1'b1;
      in  = enc(val);
      tick();
      set = 1'b0;
      v = val;
      check("set_out", out, enc(v));
      check("set_zero", zero, (v == 0));
      check("set_busy", busy, 0);
      check("set_error", error, 0);
   endtask

   // inject: 0 none, 1 step in first busy cycle, 2 set(ld) in first busy cycle, 3 toggle reverse while busy
   task automatic do_step(input bit rev, input int inject, input int ld);
      int v_next, t, exp_busy, exp_wrap, busy_cnt, wrap_cnt, guard;
      bit aborted;
      v_next   = rev ? (v + MOD - 1) % MOD : (v + 1) % MOD;
      t        = trail(v, rev ? 0 : R - 1);
      exp_busy = (t < D - 1) ? t : D - 1;
      exp_wrap = (t == D) ? 1 : 0;
      busy_cnt = 0;
      wrap_cnt = 0;
      guard    = 0;
      aborted  = 1'b0;
      step     = 1'b1;
      reverse  = rev;
      tick();
      step = 1'b0;
      while (busy && guard < 20) begin
         busy_cnt++;
         if (wrap_out) wrap_cnt++;
         if (busy_cnt == 1 && inject == 1) step = 1'b1;
         if (busy_cnt == 1 && inject == 2) begin
            set = 1'b1;
            in  = enc(ld);
            aborted = 1'b1;
         end
         if (inject == 3) reverse = ~reverse;
         tick();
         step = 1'b0;
         set  = 1'b0;
         guard++;
      end
      check("ripple_bound", (guard < 20), 1);
      if (wrap_out) wrap_cnt++;
      if (aborted) begin
         v = ld;
         exp_busy = 1;
         exp_wrap = 0;
      end else begin
         v = v_next;
      end
      check("busy_cycles", busy_cnt, exp_busy);
      check("wrap_count", wrap_cnt, exp_wrap);
      check("step_out", out, enc(v));
      check("step_zero", zero, (v == 0));
      tick();
      check("wrap_pulse", wrap_out, 0);
      check("idle_busy", busy, 0);
      check("hold_out", out, enc(v));
   endtask

   function automatic int rand_val();
      int x, m, dv;
      x = 0;
      m = 1;
      for (int d = 0; d < D; d++) begin
         case ($urandom_range(0, 2))
            0: dv = 0;
            1: dv = R - 1;
            default: dv = $urandom_range(0, R - 1);
         endcase
         x = x + dv * m;
         m = m * R;
      end
      return x;
   endfunction

   initial begin
      logic [D*R-1:0] bad;

      // reset
      #12;
      check("rst_out", out, enc(0));
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick();
      check("rst_out_rel", out, enc(0));
      check("rst_zero", zero, 1);
      check("rst_busy_rel", busy, 0);
      check("rst_wrap", wrap_out, 0);
      check("rst_error", error, 0);
      v = 0;

      // ten up-steps from 000, the tenth carries into digit 1
      for (int i = 0; i < 10; i++) do_step(1'b0, 0, 0);
      check("ten_steps", out, enc(10));

      // 999 up -> 000 with full ripple and wrap
      do_set(999);
      do_step(1'b0, 0, 0);

      // 000 down -> 999, reverse wiggled during the ripple
      do_set(0);
      do_step(1'b1, 3, 0);

      // step dropped while busy, then set aborting a ripple
      do_set(99);
      do_step(1'b0, 1, 0);
      check("drop_step", out, enc(100));
      do_set(99);
      do_step(1'b0, 2, 555);

      // non-one-hot load digit
      bad = enc(0);
      bad[1] = 1'b1;
      set = 1'b1;
      in  = bad;
      tick();
      set = 1'b0;
`ifdef DEKATRON_ONEHOT_CHECK_EN
      check("bad_load_out", out, enc(0));
      check("bad_load_error", error, 1);
      do_step(1'b0, 0, 0);
      check("error_sticky", error, 1);
`else
      check("bad_load_out", out, bad);
      check("bad_load_error", error, 0);
      check("bad_load_zero", zero, 0);
`endif
      do_set(5);

      // asynchronous reset in the middle of a ripple
      do_set(999);
      step = 1'b1;
      reverse = 1'b0;
      tick();
      step = 1'b0;
      check("mid_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out", out, enc(0));
      check("mid_rst_busy", busy, 0);
      check("mid_rst_wrap", wrap_out, 0);
      #3;
      rst_n = 1'b1;
      v = 0;
      tick();
      check("post_rst_out", out, enc(0));

      // randomized mix against the arithmetic model
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) < 2) do_set(rand_val());
         else do_step(1'($urandom_range(0, 1)), $urandom_range(0, 3), rand_val());
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
